// File: rtl/bcd_countdown_timer_pkg.sv
// Shared constants and helpers for the three-digit BCD countdown timer.
package bcd_countdown_timer_pkg;
  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX   = 4'd5;
  localparam logic [DIGIT_W-1:0] ZERO_DIGIT = 4'd0;

  // Keypad codes 10-15 are clamped to 9 before entering the shift chain.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_countdown_timer_digit_down.sv
// One BCD down-counting digit with parallel load and borrow chaining.
module bcd_digit_down
  import bcd_countdown_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] WRAP_VAL = BCD_MAX
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               dec_in,
  output logic [DIGIT_W-1:0] q,
  output logic               is_zero,
  output logic               borrow_out
);
  assign is_zero    = (q == ZERO_DIGIT);
  assign borrow_out = dec_in && is_zero;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= ZERO_DIGIT;
    end else if (ld) begin
      q <= ld_val;
    end else if (dec_in) begin
      q <= is_zero ? WRAP_VAL : q - 4'd1;
    end
  end
endmodule

// File: rtl/bcd_countdown_timer.sv
// M:SS BCD countdown timer: serial keypad load, 1 Hz decrement, zero flag.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic [0:3] CNT_in,
  input  logic       loadn,
  input  logic       en,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       zero
);
  logic               ld;
  logic [DIGIT_W-1:0] key_digit;
  logic               count_en;
  logic               ones_borrow;
  logic               tens_borrow;
  logic               unused_mins_borrow;
  logic               ones_zero;
  logic               tens_zero;
  logic               mins_zero;

  assign ld        = !loadn;
  assign key_digit = sat_digit(CNT_in);
  assign zero      = ones_zero && tens_zero && mins_zero;
  // Gating on !zero stops the chain at 0:00, so mins never borrows out of 0.
  assign count_en  = loadn && en && !zero;

  bcd_digit_down #(.WRAP_VAL(BCD_MAX)) u_sec_ones (
    .clk        (clk),
    .clrn       (clrn),
    .ld         (ld),
    .ld_val     (key_digit),
    .dec_in     (count_en),
    .q          (sec_ones),
    .is_zero    (ones_zero),
    .borrow_out (ones_borrow)
  );

  bcd_digit_down #(.WRAP_VAL(TENS_MAX)) u_sec_tens (
    .clk        (clk),
    .clrn       (clrn),
    .ld         (ld),
    .ld_val     (sec_ones),
    .dec_in     (ones_borrow),
    .q          (sec_tens),
    .is_zero    (tens_zero),
    .borrow_out (tens_borrow)
  );

  bcd_digit_down #(.WRAP_VAL(BCD_MAX)) u_mins (
    .clk        (clk),
    .clrn       (clrn),
    .ld         (ld),
    .ld_val     (sec_tens),
    .dec_in     (tens_borrow),
    .q          (mins),
    .is_zero    (mins_zero),
    .borrow_out (unused_mins_borrow)
  );
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer.
module tb_bcd_countdown_timer;
  logic       clk = 1'b0;
  logic       clrn;
  logic [0:3] CNT_in;
  logic       loadn;
  logic       en;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       zero;

  int unsigned checks = 0;
  int unsigned errors = 0;

  bcd_countdown_timer dut (
    .clk      (clk),
    .clrn     (clrn),
    .CNT_in   (CNT_in),
    .loadn    (loadn),
    .en       (en),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .mins     (mins),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %03h, expected %03h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] digits();
    return {mins, sec_tens, sec_ones};
  endfunction

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_digit(input logic [3:0] d);
    loadn  = 1'b0;
    CNT_in = d;
    tick(1);
    loadn  = 1'b1;
  endtask

  initial begin
    clrn = 1'b0; loadn = 1'b1; en = 1'b0; CNT_in = 4'd0;
    #12;
    check_val("reset_digits", digits(), 12'h000);
    check_val("reset_zero", {11'd0, zero}, 12'h001);
    clrn = 1'b1;
    tick(3);
    check_val("idle_hold", digits(), 12'h000);

    load_digit(4'd1); load_digit(4'd2); load_digit(4'd3);
    check_val("load_123", digits(), 12'h123);
    check_val("load_zero_flag", {11'd0, zero}, 12'h000);
    tick(5);
    check_val("hold_en0", digits(), 12'h123);

    en = 1'b1;
    tick(3);  check_val("count_3", digits(), 12'h120);
    tick(1);  check_val("count_4_borrow", digits(), 12'h119);
    tick(20); check_val("count_24_min_borrow", digits(), 12'h059);
    tick(59); check_val("count_83", digits(), 12'h000);
    check_val("count_83_zero", {11'd0, zero}, 12'h001);
    tick(17); check_val("terminal_hold", digits(), 12'h000);

    en = 1'b0;
    load_digit(4'd1); load_digit(4'd2); load_digit(4'd3); load_digit(4'd5);
    check_val("overflow_load", digits(), 12'h235);
    en = 1'b1;
    tick(100);
    check_val("count_100", digits(), 12'h055);
    check_val("count_100_zero", {11'd0, zero}, 12'h000);
    #3 clrn = 1'b0;
    #1 check_val("async_clear", digits(), 12'h000);
    check_val("async_clear_zero", {11'd0, zero}, 12'h001);
    @(negedge clk);
    clrn = 1'b1;
    tick(1);

    en = 1'b0;
    load_digit(4'd0); load_digit(4'd1); load_digit(4'd2);
    check_val("load_012", digits(), 12'h012);
    en = 1'b1;
    load_digit(4'd7);
    check_val("load_over_en", digits(), 12'h127);
    tick(3);  check_val("count_resume", digits(), 12'h124);
    en = 1'b0;
    tick(5);  check_val("freeze", digits(), 12'h124);
    en = 1'b1;
    tick(1);  check_val("unfreeze", digits(), 12'h123);

    en = 1'b0;
    load_digit(4'hC);
    check_val("saturate", digits(), 12'h239);

    load_digit(4'd0); load_digit(4'd7); load_digit(4'd0);
    check_val("load_tens7", digits(), 12'h070);
    en = 1'b1;
    tick(1);  check_val("tens7_dec", digits(), 12'h069);

    en = 1'b0;
    load_digit(4'd0); load_digit(4'd0); load_digit(4'd1);
    check_val("load_001", digits(), 12'h001);
    en = 1'b1;
    tick(1);  check_val("last_second", digits(), 12'h000);
    check_val("last_second_zero", {11'd0, zero}, 12'h001);
    tick(5);  check_val("last_hold", digits(), 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
